// File: rtl/fab_add_pkg.sv
// fab_add_pkg: fabric word bit positions, buffered entry layout and sink FSM states
package fab_add_pkg;
  localparam int VLD_BIT = 79;
  localparam int SOP_BIT = 78;
  localparam int EOP_BIT = 77;
  localparam int DST_HI = 76;
  localparam int DST_LO = 72;
  localparam int CH_HI = 71;
  localparam int CH_LO = 64;
  localparam int DATA_HI = 63;
  localparam int DATA_LO = 0;
  localparam int ENTRY_W = 75;
  typedef struct packed {
    logic sop;
    logic eop;
    logic err;
    logic [7:0] channel;
    logic [63:0] data;
  } entry_t;
  typedef enum logic [1:0] {IDLE, IN_PKT, DROP} state_e;
endpackage

// File: rtl/fab_sync_fifo.sv
// fab_sync_fifo: first-word-fall-through FIFO; in clk/reset_n/push/push_data/pop, out pop_data/count
module fab_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int W = 75,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic [AW:0]  count
);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  always_comb begin
    wr_d = push ? wr_q + 1'b1 : wr_q;
    rd_d = pop ? rd_q + 1'b1 : rd_q;
    cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  always_ff @(posedge clk)
    if (push) mem[wr_q] <= push_data;
  assign pop_data = mem[rd_q];
  assign count = cnt_q;
endmodule

// File: rtl/fab_add_sink.sv
// fab_add_sink: filters/frames fab_add_bus80 words for NODE_ID into a FIFO, sources Avalon-ST st_* with drop/proto counters
module fab_add_sink
  import fab_add_pkg::*;
#(
  parameter logic [4:0] NODE_ID = 5'd0,
  parameter int DEPTH = 16,
  parameter int MAX_PKT_WORDS = 8,
  parameter int AW = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [79:0] fab_add_bus80,
  input  logic        st_ready,
  output logic        st_valid,
  output logic        st_sop,
  output logic        st_eop,
  output logic        st_error,
  output logic [7:0]  st_channel,
  output logic [63:0] st_data,
  output logic [15:0] drop_pkt_cnt,
  output logic [15:0] proto_err_cnt
);
  localparam int WC_W = $clog2(MAX_PKT_WORDS + 1);
  localparam logic [AW+1:0] MAX_FREE = (AW+2)'(MAX_PKT_WORDS);
  localparam logic [WC_W-1:0] MAX_WC = WC_W'(MAX_PKT_WORDS);
  state_e state_q, state_d;
  entry_t pend_q, pend_d, pend_term, in_w, push_data, head, st_word;
  logic pend_valid_q, pend_valid_d;
  logic [WC_W-1:0] wcnt_q, wcnt_d;
  logic [15:0] drop_q, drop_d, proto_q, proto_d;
  logic [AW:0] count;
  logic [AW+1:0] free;
  logic hit, admit, push, pop, drop_inc, err_inc;
  assign hit = fab_add_bus80[VLD_BIT] && fab_add_bus80[DST_HI:DST_LO] == NODE_ID;
  assign in_w = '{sop: fab_add_bus80[SOP_BIT], eop: fab_add_bus80[EOP_BIT], err: 1'b0,
                  channel: fab_add_bus80[CH_HI:CH_LO], data: fab_add_bus80[DATA_HI:DATA_LO]};
  // pend counts against space so an admitted packet always fits, even with no pops
  assign free = (AW+2)'(DEPTH) - (AW+2)'(count) - (AW+2)'(pend_valid_q);
  assign admit = free >= MAX_FREE;
  always_comb begin
    state_d = state_q;
    pend_d = pend_q;
    pend_valid_d = pend_valid_q;
    wcnt_d = wcnt_q;
    pend_term = pend_q;
    pend_term.eop = 1'b1;
    pend_term.err = 1'b1;
    push = 1'b0;
    push_data = pend_q;
    drop_inc = 1'b0;
    err_inc = 1'b0;
    // a completed packet leaves pend on its own the cycle after its eop lands
    if (pend_valid_q && pend_q.eop) begin
      push = 1'b1;
      pend_valid_d = 1'b0;
    end
    if (hit) begin
      if (in_w.sop) begin
        // sop inside a packet terminates the open one as a repaired packet
        if (state_q == IN_PKT) begin
          push = 1'b1;
          push_data = pend_term;
          pend_valid_d = 1'b0;
          err_inc = 1'b1;
        end
        if (admit) begin
          pend_d = in_w;
          pend_valid_d = 1'b1;
          wcnt_d = WC_W'(1);
          state_d = in_w.eop ? IDLE : IN_PKT;
        end else begin
          drop_inc = 1'b1;
          state_d = in_w.eop ? IDLE : DROP;
        end
      end else if (state_q == IDLE) begin
        err_inc = 1'b1;
      end else if (state_q == DROP) begin
        state_d = in_w.eop ? IDLE : DROP;
      end else if (wcnt_q < MAX_WC) begin
        push = 1'b1;
        pend_d = in_w;
        wcnt_d = wcnt_q + 1'b1;
        state_d = in_w.eop ? IDLE : IN_PKT;
      end else begin
        // overlong packet: close it on the last legal word and shed the rest
        pend_d = pend_term;
        err_inc = 1'b1;
        state_d = in_w.eop ? IDLE : DROP;
      end
    end
    drop_d = (drop_inc && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
    proto_d = (err_inc && proto_q != 16'hFFFF) ? proto_q + 16'd1 : proto_q;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      pend_q <= '0;
      pend_valid_q <= 1'b0;
      wcnt_q <= '0;
      drop_q <= '0;
      proto_q <= '0;
    end else begin
      state_q <= state_d;
      pend_q <= pend_d;
      pend_valid_q <= pend_valid_d;
      wcnt_q <= wcnt_d;
      drop_q <= drop_d;
      proto_q <= proto_d;
    end
  fab_sync_fifo #(.DEPTH(DEPTH), .W(ENTRY_W), .AW(AW)) u_fifo (
    .clk(clk),
    .reset_n(reset_n),
    .push(push),
    .push_data(push_data),
    .pop(pop),
    .pop_data(head),
    .count(count)
  );
  assign st_valid = count != '0;
  assign pop = st_valid && st_ready;
  assign st_word = st_valid ? head : '0;
  assign st_sop = st_word.sop;
  assign st_eop = st_word.eop;
  assign st_error = st_word.err;
  assign st_channel = st_word.channel;
  assign st_data = st_word.data;
  assign drop_pkt_cnt = drop_q;
  assign proto_err_cnt = proto_q;
endmodule

// File: tb/tb_fab_add_sink.sv
// tb_fab_add_sink: directed vectors against fab_add_sink with NODE_ID=3
module tb_fab_add_sink;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic st_ready = 1'b1;
  logic [79:0] fab = '0;
  logic st_valid, st_sop, st_eop, st_error;
  logic [7:0] st_channel;
  logic [63:0] st_data;
  logic [15:0] drop_pkt_cnt, proto_err_cnt;
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int first_cyc = -1;
  int sop_cyc = 0;
  logic [74:0] q[$];
  always #5 clk = ~clk;
  fab_add_sink #(.NODE_ID(5'd3)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .fab_add_bus80(fab),
    .st_ready(st_ready),
    .st_valid(st_valid),
    .st_sop(st_sop),
    .st_eop(st_eop),
    .st_error(st_error),
    .st_channel(st_channel),
    .st_data(st_data),
    .drop_pkt_cnt(drop_pkt_cnt),
    .proto_err_cnt(proto_err_cnt)
  );
  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(negedge clk);
    if (st_valid && first_cyc < 0) first_cyc = cyc;
    if (st_valid && st_ready) q.push_back({st_sop, st_eop, st_error, st_channel, st_data});
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic idle(input int n);
    repeat (n) step();
  endtask
  task automatic send(input logic [4:0] dst, input logic sop, input logic eop, input logic [7:0] ch, input logic [63:0] d);
    fab = {1'b1, sop, eop, dst, ch, d};
    step();
    fab = '0;
  endtask
  task automatic send_pkt(input logic [4:0] dst, input int n, input logic [63:0] base);
    for (int i = 0; i < n; i++) send(dst, i == 0, i == n - 1, base[7:0], base + 64'(i));
  endtask
  task automatic exp_pkt(input string tag, input int n, input logic [63:0] base, input logic trunc);
    logic [79:0] got;
    for (int i = 0; i < n; i++) begin
      got = q.size() != 0 ? {5'b0, q.pop_front()} : '1;
      chk($sformatf("%s_w%0d", tag, i), got,
          {5'b0, i == 0, i == n - 1, trunc && i == n - 1, base[7:0], base + 64'(i)});
    end
  endtask
  initial begin
    idle(2);
    chk("rst_valid", 80'(st_valid), 80'd0);
    chk("rst_data", {st_sop, st_eop, st_error, st_channel, st_data}, 80'd0);
    chk("rst_cnts", {drop_pkt_cnt, proto_err_cnt}, 80'd0);
    reset_n = 1'b1;
    idle(1);
    sop_cyc = cyc;
    send(3, 1, 0, 8'h5A, 64'h11);
    send(3, 0, 0, 8'h5A, 64'h22);
    send(3, 0, 1, 8'h5A, 64'h33);
    idle(5);
    chk("t1_latency", 80'(first_cyc - sop_cyc), 80'd2);
    chk("t1_w0", {5'b0, q.size() > 0 ? q.pop_front() : '1}, {5'b0, 1'b1, 1'b0, 1'b0, 8'h5A, 64'h11});
    chk("t1_w1", {5'b0, q.size() > 0 ? q.pop_front() : '1}, {5'b0, 1'b0, 1'b0, 1'b0, 8'h5A, 64'h22});
    chk("t1_w2", {5'b0, q.size() > 0 ? q.pop_front() : '1}, {5'b0, 1'b0, 1'b1, 1'b0, 8'h5A, 64'h33});
    send(3, 1, 0, 8'hA1, 64'hA1);
    send(4, 1, 0, 8'hB1, 64'hB1);
    send(3, 0, 0, 8'hA1, 64'hA2);
    send(4, 0, 1, 8'hB1, 64'hB2);
    send(3, 0, 1, 8'hA1, 64'hA3);
    idle(5);
    exp_pkt("t2", 3, 64'hA1, 1'b0);
    chk("t2_extra", 80'(q.size()), 80'd0);
    chk("t2_cnts", {drop_pkt_cnt, proto_err_cnt}, 80'd0);
    st_ready = 1'b0;
    send_pkt(3, 8, 64'h100);
    send_pkt(3, 8, 64'h200);
    send_pkt(3, 3, 64'h300);
    idle(2);
    chk("t3_drop", 80'(drop_pkt_cnt), 80'd1);
    chk("t3_full_valid", 80'(st_valid), 80'd1);
    chk("t3_hold_data", 80'(st_data), 80'h100);
    st_ready = 1'b1;
    idle(20);
    exp_pkt("t3a", 8, 64'h100, 1'b0);
    exp_pkt("t3b", 8, 64'h200, 1'b0);
    chk("t3_extra", 80'(q.size()), 80'd0);
    send_pkt(3, 3, 64'h400);
    idle(5);
    exp_pkt("t3d", 3, 64'h400, 1'b0);
    chk("t3_proto", 80'(proto_err_cnt), 80'd0);
    send(3, 1, 0, 8'h51, 64'h51);
    send(3, 0, 0, 8'h51, 64'h52);
    send_pkt(3, 3, 64'h61);
    idle(5);
    exp_pkt("t4a", 2, 64'h51, 1'b1);
    exp_pkt("t4b", 3, 64'h61, 1'b0);
    chk("t4_proto", 80'(proto_err_cnt), 80'd1);
    send_pkt(3, 10, 64'h70);
    idle(5);
    exp_pkt("t5", 8, 64'h70, 1'b1);
    chk("t5_extra", 80'(q.size()), 80'd0);
    chk("t5_cnts", {drop_pkt_cnt, proto_err_cnt}, {48'd0, 16'd1, 16'd2});
    st_ready = 1'b0;
    for (int i = 0; i < 6; i++) send(3, i == 0, 1'b0, 8'h80, 64'h80 + 64'(i));
    idle(1);
    chk("t6_pre_valid", 80'(st_valid), 80'd1);
    reset_n = 1'b0;
    #1;
    chk("t6_rst_valid", 80'(st_valid), 80'd0);
    chk("t6_rst_cnts", {drop_pkt_cnt, proto_err_cnt}, 80'd0);
    step();
    reset_n = 1'b1;
    st_ready = 1'b1;
    idle(1);
    chk("t6_empty", 80'(st_valid), 80'd0);
    send_pkt(3, 2, 64'h91);
    idle(5);
    exp_pkt("t6", 2, 64'h91, 1'b0);
    chk("t6_extra", 80'(q.size()), 80'd0);
    chk("t6_cnts", {drop_pkt_cnt, proto_err_cnt}, 80'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fab_add_sink.md
Name: fab_add_sink

Overview:
- Receiving end of the 80-bit fabric add bus (fab_add_bus80) driven by msi_fabric_if.
- Filters words addressed to this node and frames them into packets; repairs or drops malformed packets.
- Buffers packets in a FIFO and presents them as an Avalon-ST source toward the local MSI consumer.
- The fabric has no backpressure, so admission is decided per packet at start-of-packet (SOP).

Parameters:
- NODE_ID, 5'd0: destination id this sink accepts.
- DEPTH, 16: FIFO entries, power of two, DEPTH >= MAX_PKT_WORDS.
- MAX_PKT_WORDS, 8: longest legal packet in words.
- AW, 4: log2(DEPTH).

Ports:
- clk  in  1  sole clock
- reset_n  in  1  asynchronous active-low reset
- fab_add_bus80  in  80  fabric word: [79] vld, [78] sop, [77] eop, [76:72] dst_id, [71:64] channel, [63:0] data
- st_ready  in  1  sink ready
- st_valid  out  1  output word valid
- st_sop  out  1  first word of packet
- st_eop  out  1  last word of packet
- st_error  out  1  packet truncated or repaired, qualified with st_eop
- st_channel  out  8  channel from the fabric word
- st_data  out  64  payload
- drop_pkt_cnt  out  16  saturating count of packets dropped for lack of space
- proto_err_cnt  out  16  saturating count of protocol errors

Behaviour:
- Reset: all outputs 0, FIFO empty, pend_valid=0, FSM=IDLE, counters 0. Reset mid-packet discards the packet and all FIFO contents.
- Hit: vld=1 and dst_id==NODE_ID. Non-hit words are ignored and never counted.
- free = DEPTH - fifo_count - pend_valid.
- Pending register (pend): holds the most recent accepted word with {sop,eop,err,channel,data}.
  - pend is written to the FIFO when the next accepted word arrives, or on the cycle after it captured an eop word.
  - At most one FIFO push per cycle.
- FSM states: IDLE, IN_PKT, DROP.
  - IDLE, hit with sop, free >= MAX_PKT_WORDS: capture into pend, wcnt=1. If eop, stay IDLE; else go IN_PKT.
  - IDLE, hit with sop, free < MAX_PKT_WORDS: drop_pkt_cnt++. If eop, stay IDLE; else go DROP.
  - IDLE, hit without sop: discard, proto_err_cnt++.
  - IN_PKT, hit without sop, wcnt < MAX_PKT_WORDS: push pend, capture word, wcnt++. On eop go IDLE.
  - IN_PKT, hit without sop, wcnt == MAX_PKT_WORDS: force pend eop=1 err=1, discard word, proto_err_cnt++. If the word lacks eop go DROP; else IDLE.
  - IN_PKT, hit with sop: push pend with eop=1 err=1, proto_err_cnt++, then process the word as IDLE+sop in the same cycle. Admission uses free after that push.
  - DROP: discard hits until an eop hit, then go IDLE. An sop hit in DROP is handled as IDLE+sop.
- Latency: an eop word arriving at cycle N sits in pend at N+1, is in the FIFO at N+2, and st_valid=1 at N+2 if the FIFO was empty. First-word-fall-through; the FIFO never overflows by construction.
- Output transfer: st_valid && st_ready pops one entry. Outputs hold stable while st_valid && !st_ready.
- Simultaneous push and pop on a full FIFO is legal.
- Counters saturate at 16'hFFFF.

Decomposition:
- Package fab_add_pkg: bit-position constants for vld/sop/eop/dst_id/channel/data, FIFO entry width (75), FSM state encoding.
- One sub-module fab_sync_fifo: parameterised DEPTH/width, FWFT, with count, async active-low reset.

Test Plan:
- NODE_ID=3, 3-word packet (sop data 0x11, 0x22, eop 0x33), st_ready=1 -> three beats, sop on the first, eop on 0x33, error=0. First st_valid exactly 2 cycles after the sop word.
- Packet with dst_id=4 interleaved with dst_id=3 traffic -> only dst 3 words appear, counters remain 0.
- st_ready=0 while sending 2 packets of 8 words (fills 16), then a third sop -> drop_pkt_cnt=1 and third packet absent. After draining, a fourth packet is accepted intact.
- sop, data, then a new sop without eop -> first packet ends on its 2nd word with st_eop=1 and st_error=1, second packet intact, proto_err_cnt=1.
- 10-word packet with MAX_PKT_WORDS=8 -> 8 words output, last with eop=1 and error=1, words 9-10 dropped, proto_err_cnt=1.
- reset_n low for one cycle mid-packet with 5 words buffered -> st_valid=0 immediately, FIFO empty, next clean packet delivered correctly.
